// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad responder: FSM states, key_code field
// positions and the column one-hot decode.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    BOUNCE,
    HOLD,
    GAP
  } state_t;

  localparam int ROW_LSB = 0;
  localparam int COL_LSB = 2;

  // Column field 2'b11 has no key behind it, so it decodes to no column at all.
  function automatic logic [2:0] col_onehot(input logic [1:0] col);
    case (col)
      2'd0:    col_onehot = 3'b001;
      2'd1:    col_onehot = 3'b010;
      2'd2:    col_onehot = 3'b100;
      default: col_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/keypad_round_counter.sv
// Scan-round counter (saturating) and round-boundary watchdog for the keypad responder.
// Both counters clear on clear; the watchdog also restarts on every round boundary.
module keypad_round_counter
  import keypad_pkg::*;
#(
  parameter int RMAX    = 4,
  parameter int RND_W   = 3,
  parameter int TIMEOUT = 1048576,
  parameter int CNT_W   = 21
) (
  input  logic             fin,
  input  logic             rst,
  input  logic             rise0,
  input  logic             clear,
  input  logic             enable,
  output logic [RND_W-1:0] rounds,
  output logic             tmo_tc
);

  logic [CNT_W-1:0] tcnt;

  always_ff @(posedge fin) begin
    if (rst || clear) begin
      rounds <= '0;
    end else if (enable && rise0 && (rounds != RND_W'(RMAX))) begin
      rounds <= rounds + RND_W'(1);
    end

    if (rst || clear || rise0) begin
      tcnt <= '0;
    end else if (enable && (tcnt != CNT_W'(TIMEOUT))) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  // Flags the cycle whose increment would reach TIMEOUT; a round boundary
  // in that same cycle takes precedence and restarts the count instead.
  assign tmo_tc = enable && !rise0 && (tcnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/keypad_responder.sv
// keypad_responder: far-end model of a 4x3 matrix keypad answering a one-hot row scan.
// Define KEYPAD_BOUNCE_EN to insert 384-cycle contact-bounce windows at press and release.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_ROUNDS = 4,
  parameter int GAP_ROUNDS  = 2,
  parameter int TIMEOUT     = 1048576,
  parameter int CNT_W       = 21
) (
  input  logic       fin,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] scan,
  output logic [2:0] colum,
  output logic       busy,
  output logic       done,
  output logic       err
);
  // state  | meaning
  // IDLE   | waiting for a command, key_ready high
  // PRESS  | command latched, waiting for a scan round boundary
  // BOUNCE | contact bounce window around press/release
  // HOLD   | key closed, column driven while its row is scanned
  // GAP    | key released, waiting out the gap rounds

  localparam int RMAX  = (HOLD_ROUNDS > GAP_ROUNDS) ? HOLD_ROUNDS : GAP_ROUNDS;
  localparam int RND_W = $clog2(RMAX + 1);

  state_t           state;
  logic [3:0]       scan_q, scan_prev;
  logic [1:0]       row_q;
  logic [2:0]       col_q;
  logic [RND_W-1:0] rounds;
  logic             rise0, row_hit, hold_end, gap_end;
  logic             cnt_clear, cnt_en, tmo_tc, drive;

  assign rise0    = scan_q[0] & ~scan_prev[0];
  assign row_hit  = (scan_q == (4'b0001 << row_q));
  assign hold_end = (state == HOLD) && rise0 && (rounds == RND_W'(HOLD_ROUNDS - 1));
  assign gap_end  = (state == GAP) && rise0 && (rounds == RND_W'(GAP_ROUNDS - 1));
  assign cnt_en   = (state == PRESS) || (state == HOLD) || (state == GAP);

`ifdef KEYPAD_BOUNCE_EN
  localparam int BOUNCE_LEN = 384;
  logic [8:0] bcnt;
  logic       gate, to_gap, bounce_exit;

  assign bounce_exit = (state == BOUNCE) && (bcnt == 9'(BOUNCE_LEN - 1));
  assign drive       = (state == HOLD) || ((state == BOUNCE) && gate);
  assign cnt_clear   = (state == IDLE) || ((state == PRESS) && rise0) || hold_end || bounce_exit;
`else
  assign drive       = (state == HOLD);
  assign cnt_clear   = (state == IDLE) || ((state == PRESS) && rise0) || hold_end;
`endif

  keypad_round_counter #(
    .RMAX   (RMAX),
    .RND_W  (RND_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .fin   (fin),
    .rst   (rst),
    .rise0 (rise0),
    .clear (cnt_clear),
    .enable(cnt_en),
    .rounds(rounds),
    .tmo_tc(tmo_tc)
  );

  always_ff @(posedge fin) begin
    if (rst) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      colum     <= 3'b000;
      row_q     <= 2'd0;
      col_q     <= 3'b000;
      scan_q    <= 4'b0000;
      scan_prev <= 4'b0000;
`ifdef KEYPAD_BOUNCE_EN
      bcnt      <= '0;
      gate      <= 1'b0;
      to_gap    <= 1'b0;
`endif
    end else begin
      scan_q    <= scan;
      scan_prev <= scan_q;
      done      <= 1'b0;
      err       <= 1'b0;
      colum     <= (drive && row_hit) ? col_q : 3'b000;

      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          busy      <= 1'b0;
          if (key_valid && key_ready) begin
            if (key_code[COL_LSB +: 2] == 2'b11) begin
              err <= 1'b1;
            end else begin
              state     <= PRESS;
              busy      <= 1'b1;
              key_ready <= 1'b0;
              row_q     <= key_code[ROW_LSB +: 2];
              col_q     <= col_onehot(key_code[COL_LSB +: 2]);
            end
          end
        end
        PRESS: begin
          if (rise0) begin
`ifdef KEYPAD_BOUNCE_EN
            state  <= BOUNCE;
            bcnt   <= '0;
            gate   <= 1'b1;
            to_gap <= 1'b0;
`else
            state <= HOLD;
`endif
          end else if (tmo_tc) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            colum <= 3'b000;
          end
        end
        HOLD: begin
          if (hold_end) begin
`ifdef KEYPAD_BOUNCE_EN
            state  <= BOUNCE;
            bcnt   <= '0;
            gate   <= 1'b1;
            to_gap <= 1'b1;
`else
            state <= GAP;
            colum <= 3'b000;
`endif
          end else if (tmo_tc) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            colum <= 3'b000;
          end
        end
        GAP: begin
          if (gap_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo_tc) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            colum <= 3'b000;
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        BOUNCE: begin
          bcnt <= bcnt + 9'd1;
          if (bcnt[5:0] == 6'd63) begin
            gate <= ~gate;
          end
          if (bounce_exit) begin
            state <= to_gap ? GAP : HOLD;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          colum <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_responder.sv
// Directed bench for keypad_responder with HOLD_ROUNDS=2, GAP_ROUNDS=1, TIMEOUT=200
// and a scan that rotates one row every 16 fin cycles.
module tb_keypad_responder;

  logic       fin = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] scan;
  logic [2:0] colum;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;
  int ph    = 0;
  int base  = 0;
  int mode  = 0;

  keypad_responder #(
    .HOLD_ROUNDS(2),
    .GAP_ROUNDS (1),
    .TIMEOUT    (200),
    .CNT_W      (8)
  ) dut (
    .fin      (fin),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .scan     (scan),
    .colum    (colum),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 fin = ~fin;

  // Scan source: after edge n the scan is row (n/16)%4, or all-zero in mode 1.
  initial begin
    scan = 4'b0000;
    forever begin
      @(posedge fin);
      #1;
      ph++;
      scan = (mode == 0) ? (4'b0001 << ph[5:4]) : 4'b0000;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return at the falling edge following rising edge number base+n.
  task automatic at(input int n);
    int lim = 0;
    while ((ph < base + n) && (lim < 100000)) begin
      @(negedge fin);
      lim++;
    end
  endtask

  task automatic sync_base();
    @(negedge fin);
    while ((ph % 64) != 0) @(negedge fin);
    base = ph;
  endtask

  initial begin
    int hi, bad_col, busy_lo, first_hi, last_hi, pulses;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(posedge fin);
    @(negedge fin);
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_colum",     32'(colum),     32'd0);
    rst = 1'b0;

    // key 5: row 1, column 010
    sync_base();
    at(3);
    key_valid = 1'b1;
    key_code  = 4'd5;
    at(4);
    key_valid = 1'b0;
    chk("k5_busy_on",   32'(busy),      32'd1);
    chk("k5_ready_off", 32'(key_ready), 32'd0);
    at(65);  chk("k5_press_colum",  32'(colum), 32'd0);
    at(81);  chk("k5_latency_lo",   32'(colum), 32'd0);
    at(82);  chk("k5_win1_start",   32'(colum), 32'd2);
    at(97);  chk("k5_win1_end",     32'(colum), 32'd2);
    at(98);  chk("k5_win1_off",     32'(colum), 32'd0);
    at(146); chk("k5_win2_start",   32'(colum), 32'd2);
    at(161); chk("k5_win2_end",     32'(colum), 32'd2);
    at(162); chk("k5_win2_off",     32'(colum), 32'd0);
    at(210); chk("k5_gap_colum",    32'(colum), 32'd0);
    at(257);
    chk("k5_pre_done", 32'(done), 32'd0);
    chk("k5_pre_busy", 32'(busy), 32'd1);
    at(258);
    chk("k5_done",       32'(done),      32'd1);
    chk("k5_busy_off",   32'(busy),      32'd0);
    chk("k5_ready_lag",  32'(key_ready), 32'd0);
    at(259);
    chk("k5_done_1cyc",  32'(done),      32'd0);
    chk("k5_ready_back", 32'(key_ready), 32'd1);

    // key 11: row 3, column 100
    sync_base();
    at(3);
    key_valid = 1'b1;
    key_code  = 4'd11;
    at(4);
    key_valid = 1'b0;
    hi = 0; bad_col = 0; busy_lo = 0; first_hi = -1; last_hi = -1;
    for (int n = 4; n <= 257; n++) begin
      at(n);
      if (colum == 3'b100) begin
        hi++;
        if (first_hi < 0) first_hi = n;
        last_hi = n;
      end else if (colum != 3'b000) begin
        bad_col++;
      end
      if (!busy) busy_lo++;
    end
    chk("k11_hi_cycles", 32'(hi),       32'd32);
    chk("k11_bad_colum", 32'(bad_col),  32'd0);
    chk("k11_first_hi",  32'(first_hi), 32'd114);
    chk("k11_last_hi",   32'(last_hi),  32'd193);
    chk("k11_busy_held", 32'(busy_lo),  32'd0);
    at(258);
    chk("k11_done", 32'(done), 32'd1);
    chk("k11_busy", 32'(busy), 32'd0);

    // key 13: illegal column field
    at(260);
    key_valid = 1'b1;
    key_code  = 4'd13;
    at(261);
    key_valid = 1'b0;
    chk("k13_err",   32'(err),       32'd1);
    chk("k13_ready", 32'(key_ready), 32'd1);
    chk("k13_busy",  32'(busy),      32'd0);
    chk("k13_colum", 32'(colum),     32'd0);
    at(262);
    chk("k13_err_1cyc", 32'(err),  32'd0);
    chk("k13_busy_lo",  32'(busy), 32'd0);

    // timeout: scan parked at 0000 after accepting key 0
    at(265);
    mode = 1;
    at(275);
    key_valid = 1'b1;
    key_code  = 4'd0;
    at(276);
    key_valid = 1'b0;
    chk("tmo_busy_on", 32'(busy), 32'd1);
    pulses = 0;
    for (int n = 277; n <= 475; n++) begin
      at(n);
      if (done || err) pulses++;
    end
    chk("tmo_no_early_pulse", 32'(pulses), 32'd0);
    chk("tmo_pre_busy",       32'(busy),   32'd1);
    at(476);
    chk("tmo_err",   32'(err),   32'd1);
    chk("tmo_done",  32'(done),  32'd0);
    chk("tmo_busy",  32'(busy),  32'd0);
    chk("tmo_colum", 32'(colum), 32'd0);
    at(477);
    chk("tmo_err_1cyc", 32'(err),       32'd0);
    chk("tmo_ready",    32'(key_ready), 32'd1);
    mode = 0;

    // reset in the middle of HOLD while column 001 is driven
    sync_base();
    at(3);
    key_valid = 1'b1;
    key_code  = 4'd0;
    at(4);
    key_valid = 1'b0;
    at(70);
    chk("rsth_colum_on", 32'(colum), 32'd1);
    rst = 1'b1;
    at(71);
    chk("rsth_colum", 32'(colum),     32'd0);
    chk("rsth_ready", 32'(key_ready), 32'd1);
    chk("rsth_busy",  32'(busy),      32'd0);
    chk("rsth_done",  32'(done),      32'd0);
    chk("rsth_err",   32'(err),       32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 72; n <= 140; n++) begin
      at(n);
      if (done || err || (colum != 3'b000) || busy) pulses++;
    end
    chk("rsth_quiet",     32'(pulses),    32'd0);
    chk("rsth_ready_end", 32'(key_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
